// File: rtl/abs_max_tracker.sv
// Purpose  : tracks the largest unsigned magnitude in a LEN-sample frame and the index of its first occurrence.
// Latency  : done pulses one cycle after the edge that accepts the last sample. Results load on that same edge.
// Backpress: in_ready is high only in COLLECT. Upstream holds abs_in/in_valid until it sees in_ready.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start             begins a frame (sampled only in IDLE)
//   abs_in, in_valid  magnitude sample and its valid qualifier
//   in_ready          sample accepted on edges where in_valid && in_ready
//   busy              high in COLLECT and DONE
//   done              one-cycle pulse when max_out/max_idx hold a new frame result
//   max_out, max_idx  largest magnitude of the last completed frame and its first index
module abs_max_tracker #(
    parameter int N    = 5,
    parameter int LEN  = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    abs_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    max_out,
    output logic [IDXW-1:0] max_idx
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    state_t          r_state;
    state_t          w_next_state;
    logic [IDXW-1:0] r_count;
    logic [N-1:0]    r_run_max;
    logic [IDXW-1:0] r_run_idx;
    logic [N-1:0]    r_max_out;
    logic [IDXW-1:0] r_max_idx;

    logic            w_accept;
    logic            w_last;
    logic            w_greater;
    logic [N-1:0]    w_new_max;
    logic [IDXW-1:0] w_new_idx;

    // abs_in only matters when a beat is actually accepted.
    assign w_accept  = in_valid && (r_state == S_COLLECT);
    assign w_last    = w_accept && (r_count == LAST_IDX);

    // Strict compare: ties keep the earlier index. run_max starts at 0 so the
    // first beat always loads index 0, even for an all-zero frame.
    assign w_greater = (abs_in > r_run_max);
    assign w_new_max = w_greater ? abs_in  : r_run_max;
    assign w_new_idx = w_greater ? r_count : r_run_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately ignored here; a new frame needs IDLE.
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_run_max <= '0;
            r_run_idx <= '0;
            r_max_out <= '0;
            r_max_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count   <= '0;
                    r_run_max <= '0;
                    r_run_idx <= '0;
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_run_max <= w_new_max;
                        r_run_idx <= w_new_idx;
                        if (w_last) begin
                            // Published results include the compare of the final beat.
                            r_max_out <= w_new_max;
                            r_max_idx <= w_new_idx;
                            r_count   <= '0;
                        end else begin
                            r_count   <= r_count + IDX_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_COLLECT);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign max_out  = r_max_out;
    assign max_idx  = r_max_idx;

endmodule

// File: tb/tb_abs_max_tracker.sv
module tb_abs_max_tracker;

    localparam int N    = 5;
    localparam int LEN  = 8;
    localparam int IDXW = 3;

    logic            clk;
    logic            rst;
    logic            start;
    logic [N-1:0]    abs_in;
    logic            in_valid;
    logic            in_ready;
    logic            busy;
    logic            done;
    logic [N-1:0]    max_out;
    logic [IDXW-1:0] max_idx;

    typedef struct packed {
        logic [N-1:0]    m;
        logic [IDXW-1:0] i;
    } exp_t;

    typedef logic [N-1:0] frame_t [LEN];

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Result the DUT should be showing between completed frames.
    logic [N-1:0]    held_max = '0;
    logic [IDXW-1:0] held_idx = '0;

    abs_max_tracker #(.N(N), .LEN(LEN), .IDXW(IDXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abs_in   (abs_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .max_out  (max_out),
        .max_idx  (max_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expected result whenever the DUT presents done.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_max_out", int'(max_out), int'(e.m));
                check("sb_max_idx", int'(max_idx), int'(e.i));
                check("done_one_cycle", int'(prev_done), 0);
            end
        end
        prev_done <= done && !rst;
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_frame(input frame_t v, input bit gapped, input bit hold_start,
                             input logic [N-1:0] exp_m, input logic [IDXW-1:0] exp_i);
        exp_t e;
        e.m = exp_m;
        e.i = exp_i;
        sb_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        for (int k = 0; k < LEN; k++) begin
            in_valid = 1'b1;
            abs_in   = v[k];
            @(negedge clk);
            check("beat_in_ready", int'(in_ready), 1);
            check("beat_busy", int'(busy), 1);
            check("beat_done_low", int'(done), 0);
            check("beat_max_held", int'(max_out), int'(held_max));
            check("beat_idx_held", int'(max_idx), int'(held_idx));
            @(posedge clk); #1;
            if (gapped && k < LEN - 1) begin
                in_valid = 1'b0;
                abs_in   = 5'h1f;
                repeat (2) begin
                    @(negedge clk);
                    check("gap_in_ready", int'(in_ready), 1);
                    check("gap_busy", int'(busy), 1);
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        abs_in   = '0;
        @(negedge clk);
        check("done_latency", int'(done), 1);
        check("done_in_ready", int'(in_ready), 0);
        check("done_busy", int'(busy), 1);
        check("done_max_out", int'(max_out), int'(exp_m));
        check("done_max_idx", int'(max_idx), int'(exp_i));
        held_max = exp_m;
        held_idx = exp_i;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("idle_done", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_max_out", int'(max_out), int'(exp_m));
    endtask

    initial begin
        frame_t f_basic, f_ties, f_zero, f_same, f_b, f_ramp;
        f_basic = '{5'd3, 5'd7, 5'd2, 5'd9, 5'd1, 5'd0, 5'd4, 5'd5};
        f_ties  = '{5'd5, 5'd16, 5'd16, 5'd0, 5'd16, 5'd2, 5'd1, 5'd3};
        f_zero  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        f_same  = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4};
        f_b     = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd0};
        f_ramp  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};

        rst      = 1'b1;
        start    = 1'b0;
        abs_in   = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_max_out", int'(max_out), 0);
        check("rst_max_idx", int'(max_idx), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(f_basic, 1'b0, 1'b0, 5'd9, 3'd3);
        run_frame(f_ties, 1'b0, 1'b0, 5'd16, 3'd1);
        run_frame(f_zero, 1'b0, 1'b0, 5'd0, 3'd0);
        run_frame(f_basic, 1'b1, 1'b0, 5'd9, 3'd3);
        run_frame(f_same, 1'b0, 1'b1, 5'd4, 3'd0);
        // Results hold: A then B.
        run_frame(f_basic, 1'b0, 1'b0, 5'd9, 3'd3);
        run_frame(f_b, 1'b0, 1'b0, 5'd12, 3'd6);

        // Reset mid-frame after 4 beats.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            abs_in   = f_basic[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("arst_max_out", int'(max_out), 0);
        check("arst_max_idx", int'(max_idx), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_in_ready", int'(in_ready), 0);
        check("arst_done", int'(done), 0);
        #1;
        rst = 1'b0;
        held_max = '0;
        held_idx = '0;
        repeat (3) begin
            @(negedge clk);
            check("post_arst_busy", int'(busy), 0);
            check("post_arst_done", int'(done), 0);
        end
        run_frame(f_ramp, 1'b0, 1'b0, 5'd8, 3'd7);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/abs_max_tracker.md
Name: abs_max_tracker

Overview:
Downstream consumer of the abs_value stage. It takes a frame of LEN unsigned N-bit magnitudes over a valid/ready handshake and tracks the largest magnitude and the index of its first occurrence. When the frame completes, it reports both with a one-cycle done pulse. It sits between the magnitude datapath and the control/readout logic.

Parameters:
N, 5, magnitude width; must match the abs_value N.
LEN, 8, samples per frame; LEN >= 2.
IDXW, 3, index width; must satisfy 2**IDXW >= LEN.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begins a frame; sampled only in IDLE.
abs_in  input  N  magnitude from abs_value, unsigned; 2**(N-1) is a legal value.
in_valid  input  1  abs_in is valid this cycle.
in_ready  output  1  tracker accepts a sample this cycle.
busy  output  1  high in COLLECT and DONE.
done  output  1  one-cycle pulse; results are valid.
max_out  output  N  largest magnitude of the last completed frame.
max_idx  output  IDXW  index (0-based) of the first occurrence of max_out.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, run_max=0, run_idx=0, max_out=0, max_idx=0, in_ready=0, busy=0, done=0.
- Reset mid-frame aborts the frame immediately. No done pulse. Results return to 0.
- States: IDLE, COLLECT, DONE. Outputs are decoded from registered state: in_ready=(state==COLLECT), busy=(state!=IDLE), done=(state==DONE).
- IDLE:
  - start=1 -> COLLECT.
  - Clear count, run_max, run_idx. max_out/max_idx hold their previous values.
- COLLECT: a beat is accepted on an edge where in_valid && in_ready.
  - Per beat: if abs_in > run_max (unsigned, strict), then run_max<=abs_in and run_idx<=count. count<=count+1.
  - Ties keep the earlier index.
  - The first beat always loads run_idx=0, because run_max starts at 0; if all samples are 0, max_idx=0.
  - in_valid=0 cycles: no state change. Gaps of any length are allowed.
  - start is ignored while busy.
- Last beat (count==LEN-1 accepted):
  - Same edge: state<=DONE.
  - max_out/max_idx load the final values, including that beat's compare. count<=0.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE unconditionally.
  - start in DONE is ignored.
  - Earliest next frame: start asserted the cycle after done.
- Latency: done rises one cycle after the edge that accepts the last sample. Minimum frame time is 1 (start) + LEN + 1 (DONE) cycles.
- max_out/max_idx change only on the LEN-th accepted beat edge and on reset. They are stable between frames and during the next frame.
- Width rules:
  - count is IDXW bits and never exceeds LEN-1 (no wrap).
  - Comparison is unsigned, so the magnitude of the most negative input (2**(N-1), e.g. 16 for N=5) ranks highest.
- X-safety: abs_in is ignored when the beat is not accepted.

Test Plan:
- Basic frame: N=5, LEN=8, start, then 3,7,2,9,1,0,4,5 back-to-back -> in_ready high 8 cycles; done one cycle after the 8th accept; max_out=9, max_idx=3.
- Ties and extremes: 5,16,16,0,16,2,1,3 -> max_out=16, max_idx=1. All-zero frame -> max_out=0, max_idx=0.
- Gapped valid: same 8 values as the basic frame, with in_valid toggled 1,0,0,1,... -> identical results; done 1 cycle after the last accept; busy high throughout.
- Start ignored: assert start during COLLECT and during the DONE cycle -> no restart; count unaffected; FSM returns to IDLE after a single done pulse.
- Async reset mid-frame: reset after 4 beats, deasserted between edges -> outputs 0 immediately, no done. A following clean frame 1..8 -> max_out=8, max_idx=7.
- Results hold: after frame A (max 9 @3), run frame B (max 12 @6) -> max_out stays 9 until B's last-accept edge, then becomes 12/6.
